// File: rtl/ps2_codes_pkg.sv
// PS/2 keyboard byte constants and scancode filter state encoding.
// Shared by the scancode FIFO and the Morse encoder.
package ps2_codes_pkg;

  localparam logic [7:0] PS2_BREAK    = 8'hF0;
  localparam logic [7:0] PS2_EXT      = 8'hE0;
  localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
  localparam logic [7:0] PS2_ACK      = 8'hFA;
  localparam logic [7:0] PS2_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_ERR0     = 8'h00;
  localparam logic [7:0] PS2_ERR1     = 8'hFF;
  localparam logic [7:0] PS2_BAT_FAIL = 8'hFC;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_BREAK     = 2'd1;
  localparam logic [1:0] ST_EXT       = 2'd2;
  localparam logic [1:0] ST_EXT_BREAK = 2'd3;

  // Keyboard status/error bytes that never represent a key.
  function automatic logic is_status_byte(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_ERR1) || (b == PS2_BAT_OK) ||
           (b == PS2_ECHO) || (b == PS2_ACK)  || (b == PS2_BAT_FAIL) ||
           (b == PS2_RESEND);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo_fwft #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [WIDTH-1:0]  i_data,
  input  logic              i_pop,
  input  logic              i_clear,
  output logic [WIDTH-1:0]  o_data,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty
);

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_push;
  logic              w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_MAX);
  assign o_count = r_count;
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  // Head is forced to zero while empty so the output never shows stale storage.
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/ps2_scancode_fifo.sv
// Filters PS/2 break, extended and status bytes and queues make codes
// for the Morse encoder behind a valid/ready handshake.
module ps2_scancode_fifo
  import ps2_codes_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        ps2_received_data,
  input  logic              ps2_received_data_strb,
  input  logic              clear,
  output logic [7:0]        code_data,
  output logic              code_valid,
  input  logic              code_ready,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       w_push_req;
  logic       w_full;
  logic       w_empty;
  logic       r_overflow;

  always_comb begin
    w_state_next = ST_IDLE;
    w_push_req   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ps2_received_data == PS2_BREAK)    w_state_next = ST_BREAK;
        else if (ps2_received_data == PS2_EXT) w_state_next = ST_EXT;
        else if (!is_status_byte(ps2_received_data))
          w_push_req = ps2_received_data_strb & ~clear;
      end
      ST_EXT: begin
        if (ps2_received_data == PS2_BREAK) w_state_next = ST_EXT_BREAK;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_state    <= ST_IDLE;
      r_overflow <= 1'b0;
    end else begin
      if (ps2_received_data_strb) r_state <= w_state_next;
      // code_ready while full always means a pop, which makes room.
      if (w_push_req && w_full && !code_ready) r_overflow <= 1'b1;
    end
  end

  sync_fifo_fwft #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push_req),
    .i_data  (ps2_received_data),
    .i_pop   (code_ready),
    .i_clear (clear),
    .o_data  (code_data),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign code_valid = ~w_empty;
  assign overflow   = r_overflow;

endmodule

// File: doc/ps2_scancode_fifo.md
Name: ps2_scancode_fifo

Overview:
- Sits between ps2_controller and morse_code_encoder.
- Strips PS/2 break sequences (F0 xx), extended sequences (E0 xx, E0 F0 xx) and keyboard status bytes.
- Buffers the remaining make codes in a first-word-fall-through FIFO.
- Hands codes downstream over a valid/ready handshake, so the encoder never misses a key typed faster than Morse playback.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
ADDR_W, 4, log2(DEPTH)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
ps2_received_data  input  8  byte from ps2_controller
ps2_received_data_strb  input  1  one-cycle pulse, ps2_received_data valid
clear  input  1  synchronous flush
code_data  output  8  head-of-FIFO make code
code_valid  output  1  FIFO not empty
code_ready  input  1  consumer accepts code_data this cycle
fifo_count  output  ADDR_W+1  entries currently stored
overflow  output  1  sticky: a make code was dropped because the FIFO was full

Behaviour:
- Reset (rst_n low, asynchronous):
  - code_data=8'h00, code_valid=0, fifo_count=0, overflow=0.
  - Filter FSM goes to IDLE; read/write pointers go to 0.
  - Asserting rst_n low mid-transfer aborts everything; no stored entries survive.
- Filter FSM advances only on cycles with ps2_received_data_strb=1. Four states:
  - IDLE:
    - F0 -> BREAK.
    - E0 -> EXT.
    - 00, AA, EE, FA, FC, FE, FF -> dropped, stay IDLE.
    - Any other byte -> push, stay IDLE.
  - BREAK: any byte is dropped -> IDLE.
  - EXT:
    - F0 -> EXT_BREAK.
    - Any other byte is dropped (extended keys unsupported) -> IDLE.
  - EXT_BREAK: any byte is dropped -> IDLE.
- Typematic repeats (the same make code again without a break in between) are pushed every time.
- Strobes on consecutive clock cycles are each processed; no minimum spacing.
- FIFO:
  - A push writes on the clock edge after the strobe.
  - If the FIFO was empty, code_valid and code_data become valid in that same cycle: 1-cycle latency from strobe to code_valid.
  - code_data always shows the oldest entry and is stable while code_valid=1 and code_ready=0.
  - Pop happens when code_valid & code_ready at the clock edge. code_ready while empty has no effect.
- Same-cycle push and pop:
  - Both are performed; fifo_count is unchanged.
  - This holds when full: the push is accepted and overflow is not set.
  - When empty, only the push occurs (nothing to pop).
- Push when full without a simultaneous pop: the byte is discarded, overflow<=1, FIFO contents unchanged.
- overflow stays set until clear or reset.
- clear:
  - Next edge: pointers=0, fifo_count=0, code_valid=0, overflow=0, FSM=IDLE.
  - clear has priority over a same-cycle strobe (that byte is discarded) and over a same-cycle pop.
- Pointers are ADDR_W bits and wrap modulo DEPTH. fifo_count saturates at DEPTH by construction (never DEPTH+1).
- FIFO storage needs no reset; only pointers, count and flags are reset.

Decomposition:
- Package ps2_codes_pkg holds:
  - byte constants PS2_BREAK=F0, PS2_EXT=E0, PS2_BAT_OK=AA, PS2_ACK=FA, PS2_ECHO=EE, PS2_RESEND=FE, PS2_ERR0=00, PS2_ERR1=FF, PS2_BAT_FAIL=FC;
  - the filter FSM state encoding (IDLE, BREAK, EXT, EXT_BREAK).
- Shared with morse_code_encoder, which currently hardcodes the break byte.
- One sub-module: sync_fifo_fwft (parameterised DEPTH/width, with push, pop, clear, count, full and empty). The top holds the filter FSM and the overflow flag.

Test Plan:
- Reset: hold rst_n=0 with strobes active -> code_valid=0, fifo_count=0, overflow=0. Release, send 1C with code_ready=0 -> code_valid=1 one cycle after the strobe, code_data=1C, fifo_count=1.
- Break filtering: strobes F0, 1C, then 32 -> only 32 queued, fifo_count=1. Then AA and FA -> fifo_count stays 1.
- Extended filtering: E0 75, then E0 F0 75, then 29 -> only 29 queued; FSM back in IDLE (verified by 29 being accepted).
- Order and overflow: code_ready=0, push 17 distinct codes 01..11 -> fifo_count=16, overflow=1. Then code_ready=1 -> 01..10 emitted in order, one per cycle, then code_valid=0, overflow still 1.
- Full with simultaneous push/pop: with the FIFO full, pulse code_ready on the same cycle as strobe 1C -> fifo_count=16, overflow=0, and 1C appears as the 16th output.
- Clear and back-to-back strobes:
  - Back-to-back strobes 1C, 32 on consecutive cycles -> both queued.
  - clear together with strobe 21 -> next cycle fifo_count=0, code_valid=0, overflow=0, and 21 not queued.
